// File: rtl/conv_fifo_rd_stream.sv
// Read-side drain engine for the Conv input FIFO.
// The FIFO does not fall through and returns data a fixed number of cycles
// after each read strobe. Reads are issued only when a skid-buffer slot is
// guaranteed for the returning word. Buffered words are presented as a
// valid/ready pixel stream with frame position tags (sof, eol, eof).
// Supported RD_LATENCY range is 1..3; IMG_WIDTH and IMG_HEIGHT must be >= 2.
module conv_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic                  frame_clr,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof
);

  // One slot per word that can be in flight, plus one to cover the pop
  // turnaround, so a full-rate stream never stalls.
  localparam int BUF_DEPTH = RD_LATENCY + 1;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W     = $clog2(2 * BUF_DEPTH + 1);
  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(IMG_HEIGHT);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t                 buf_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      buf_cnt;
  logic [CNT_W-1:0]      inflight;
  logic [RD_LATENCY-1:0] pipe;
  logic                  run;
  logic                  push;
  logic                  pop;
  logic [OCC_W-1:0]      occ;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Hold off reads until one full edge after reset release.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rd_rst_n) run <= 1'b0;
    else           run <= 1'b1;
  end

  // Shift pipe marking which past cycles issued a read; its last stage
  // lines up with the cycle the FIFO presents that read's data.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= fifo_rd_en;
      for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Count reads still travelling through the FIFO read pipeline.
  always_comb begin
    // NOTE: default assigned first so no path leaves the result unassigned (no latch).
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CNT_W'(pipe[i]);
  end

  assign push    = pipe[RD_LATENCY-1];
  assign m_valid = (buf_cnt != '0);
  assign pop     = m_valid & m_ready;

  // Occupancy committed once this cycle's pop retires: buffered + in flight.
  assign occ = OCC_W'(buf_cnt) + OCC_W'(inflight) - OCC_W'(pop);

  assign fifo_rd_en = run & ~fifo_rd_empty & (occ < OCC_W'(BUF_DEPTH));

  // Skid buffer data storage, written at the tail when returning data lands.
  always_ff @(posedge rd_clk) begin
    // NOTE: storage is not reset; m_data is masked by m_valid so stale contents never reach the port.
    if (push) buf_mem[wr_ptr] <= fifo_rd_data;
  end

  // Skid buffer pointers and fill count; push and pop together cancel.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      buf_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   buf_cnt <= buf_cnt + 1'b1;
        2'b01:   buf_cnt <= buf_cnt - 1'b1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Position of the head beat; advances on pop, frame_clr wins over a pop.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (frame_clr) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign m_data = m_valid ? buf_mem[rd_ptr] : '0;
  assign m_sof  = m_valid & (col == '0) & (row == '0);
  assign m_eol  = m_valid & (col == COL_LAST);
  assign m_eof  = m_eol & (row == ROW_LAST);

  // Credit accounting must keep the skid buffer within its depth.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    buf_cnt <= CNT_W'(BUF_DEPTH));

  // A landing word must always find a free slot.
  a_push_has_room: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    (push && !pop) |-> (buf_cnt < CNT_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_conv_fifo_rd_stream.sv
// Testbench for conv_fifo_rd_stream: a fixed-latency FIFO model feeds the
// DUT; every word pushed into the FIFO is also queued as an expected beat,
// and a separate monitor pops that queue on each accepted beat. Frame tags
// come from a beat index within the frame, reset by frame_clr.
module tb_conv_fifo_rd_stream;

  localparam int DW        = 8;
  localparam int LAT       = 2;
  localparam int W         = 4;
  localparam int H         = 3;
  localparam int BUF_DEPTH = LAT + 1;
  localparam int FRAME     = W * H;

  logic          rd_clk        = 1'b0;
  logic          rd_rst_n      = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data  = '0;
  logic          fifo_rd_empty = 1'b1;
  logic          frame_clr     = 1'b0;
  logic          m_valid;
  logic          m_ready       = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          m_eof;

  conv_fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .RD_LATENCY (LAT),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .rd_clk        (rd_clk),
    .rd_rst_n      (rd_rst_n),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_rd_data  (fifo_rd_data),
    .fifo_rd_empty (fifo_rd_empty),
    .frame_clr     (frame_clr),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_sof         (m_sof),
    .m_eol         (m_eol),
    .m_eof         (m_eof)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents, expected beat order, and the FIFO's read-data delay line.
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] exp_q  [$];
  logic [DW-1:0] dl     [LAT];

  int   reads = 0;   // words taken out of the FIFO since the last reset
  int   beats = 0;   // beats accepted downstream
  int   pos_k = 0;   // beat index within the current frame
  int   cyc   = 0;
  logic clr_on_col2 = 1'b0;
  logic t6_hit      = 1'b0;

  // Values sampled by the driver in the cycle just completed.
  logic rd_en_s, valid_s, pop_s, sof_s, eol_s, eof_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the FIFO model by one clock edge.
  task automatic fifo_step(input logic rd);
    for (int i = LAT - 1; i > 0; i--) dl[i] = dl[i-1];
    if (rd) begin
      if (fifo_q.size() > 0) dl[0] = fifo_q.pop_front();
      else                   dl[0] = '0;
      reads++;
    end else begin
      dl[0] = DW'($urandom);
    end
    fifo_rd_data  = dl[LAT-1];
    fifo_rd_empty = (fifo_q.size() == 0);
  endtask

  task automatic push_word();
    logic [DW-1:0] w;
    w = DW'($urandom);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_rd_empty = 1'b0;
  endtask

  // One clock: drive on the falling edge, sample, then step the FIFO model.
  task automatic cycle(input logic ready, input logic clr);
    @(negedge rd_clk);
    m_ready   = ready;
    frame_clr = clr;
    #1;
    if (clr_on_col2 && !t6_hit && m_valid && m_ready && (pos_k % W) == 2 && pos_k >= W) begin
      frame_clr = 1'b1;
      t6_hit    = 1'b1;
    end
    rd_en_s = fifo_rd_en;
    valid_s = m_valid;
    pop_s   = m_valid & m_ready;
    sof_s   = m_sof;
    eol_s   = m_eol;
    eof_s   = m_eof;
    @(posedge rd_clk);
    #1;
    fifo_step(rd_en_s);
    cyc++;
  endtask

  task automatic apply_reset(input int hold);
    @(negedge rd_clk);
    rd_rst_n  = 1'b0;
    m_ready   = 1'b0;
    frame_clr = 1'b0;
    #1;
    check("rst_outputs_zero", 32'({fifo_rd_en, m_valid, m_data, m_sof, m_eol, m_eof}), 32'(0));
    // Words already taken from the FIFO but not delivered are lost.
    while (reads > beats && exp_q.size() > 0) begin
      exp_q.delete(0);
      reads--;
    end
    reads = beats;
    repeat (hold) begin
      @(posedge rd_clk);
      #1;
      fifo_step(1'b0);
    end
    @(negedge rd_clk);
    rd_rst_n = 1'b1;
    #1;
    check("first_edge_after_release", 32'({fifo_rd_en, m_valid}), 32'(0));
    @(posedge rd_clk);
    #1;
    fifo_step(1'b0);
  endtask

  task automatic drain(input string name, input int budget);
    int g = 0;
    while (exp_q.size() != 0 && g < budget) begin
      cycle(1'b1, 1'b0);
      g++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: %0d beats pending after %0d cycles", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Monitor: protocol rules and scoreboard comparison, sampled mid-cycle.
  logic [DW+2:0] mon_cur;
  logic [DW+2:0] stall_word;
  logic          stall_prev = 1'b0;
  logic          stall_clr  = 1'b0;
  logic [DW-1:0] exp_w;
  int            mon_col, mon_row, mon_pop;

  always @(negedge rd_clk) begin
    #2;
    if (!rd_rst_n) begin
      stall_prev = 1'b0;
      pos_k      = 0;
    end else begin
      mon_cur = {m_data, m_sof, m_eol, m_eof};
      mon_pop = (m_valid && m_ready) ? 1 : 0;
      if (fifo_rd_empty) check("no_read_when_empty", 32'(fifo_rd_en), 32'(0));
      if (fifo_rd_en)
        check("read_credit", 32'((reads - beats - mon_pop + 1) <= BUF_DEPTH), 32'(1));
      if (!m_valid) check("tags_idle", 32'({m_sof, m_eol, m_eof}), 32'(0));
      if (stall_prev) begin
        check("valid_held_in_stall", 32'(m_valid), 32'(1));
        if (stall_clr) check("data_held_in_stall", 32'(mon_cur[DW+2:3]), 32'(stall_word[DW+2:3]));
        else           check("beat_held_in_stall", 32'(mon_cur), 32'(stall_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: data=%0h with no word outstanding at t=%0t", m_data, $time);
        end else begin
          exp_w   = exp_q.pop_front();
          mon_col = pos_k % W;
          mon_row = pos_k / W;
          check("beat_data", 32'(m_data), 32'(exp_w));
          check("beat_sof", 32'(m_sof), 32'(mon_col == 0 && mon_row == 0));
          check("beat_eol", 32'(m_eol), 32'(mon_col == W - 1));
          check("beat_eof", 32'(m_eof), 32'(mon_col == W - 1 && mon_row == H - 1));
        end
        beats++;
        pos_k = (pos_k + 1) % FRAME;
      end
      if (frame_clr) pos_k = 0;
      stall_prev = m_valid && !m_ready;
      stall_clr  = frame_clr;
      stall_word = mon_cur;
    end
  end

  // Stimulus sequence.
  initial begin
    int first_rd, first_v, last_pop, n, guard, idx, sof_n, eol_n, eof_n;

    for (int i = 0; i < LAT; i++) dl[i] = '0;
    #1 rd_rst_n = 1'b0;
    apply_reset(2);

    // Throughput with a preloaded FIFO and downstream always ready.
    for (int i = 0; i < 1000; i++) push_word();
    first_rd = -1; first_v = -1; last_pop = -1; n = 0; guard = 0;
    while (n < 1000 && guard < 1200) begin
      cycle(1'b1, 1'b0);
      guard++;
      if (rd_en_s && first_rd < 0) first_rd = cyc - 1;
      if (valid_s && first_v < 0)  first_v  = cyc - 1;
      if (pop_s) begin
        n++;
        last_pop = cyc - 1;
      end
    end
    check("t2_beats", 32'(n), 32'(1000));
    check("t2_fill_latency", 32'(first_v - first_rd), 32'(LAT + 1));
    check("t2_span_cycles", 32'(last_pop - first_v + 1), 32'(1000));

    // Reset mid-stream with reads in flight; stale words must vanish.
    for (int i = 0; i < 20; i++) push_word();
    repeat (6) cycle(1'b1, 1'b0);
    apply_reset(2);
    drain("t1", 200);

    // Random backpressure, random arrivals, occasional frame_clr.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 55) push_word();
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 31) == 0);
    end
    drain("t3", 2000);

    // Two full frames from a cleared position.
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 2 * FRAME; i++) push_word();
    idx = 0; sof_n = 0; eol_n = 0; eof_n = 0; guard = 0;
    while (idx < 2 * FRAME && guard < 100) begin
      cycle(1'b1, 1'b0);
      guard++;
      if (pop_s) begin
        check("t4_sof", 32'(sof_s), 32'(idx == 0 || idx == 12));
        check("t4_eol", 32'(eol_s), 32'((idx % 4) == 3));
        check("t4_eof", 32'(eof_s), 32'(idx == 11 || idx == 23));
        sof_n += 32'(sof_s);
        eol_n += 32'(eol_s);
        eof_n += 32'(eof_s);
        idx++;
      end
    end
    check("t4_beat_count", 32'(idx), 32'(2 * FRAME));
    check("t4_sof_count", 32'(sof_n), 32'(2));
    check("t4_eol_count", 32'(eol_n), 32'(6));
    check("t4_eof_count", 32'(eof_n), 32'(2));

    // Underrun: idle while empty, then a single word gives a single beat.
    repeat (6) begin
      cycle(1'b1, 1'b0);
      check("t5_no_read_idle", 32'(rd_en_s), 32'(0));
      check("t5_valid_low_idle", 32'(valid_s), 32'(0));
    end
    push_word();
    n = 0;
    repeat (10) begin
      cycle(1'b1, 1'b0);
      if (pop_s) n++;
    end
    check("t5_single_beat", 32'(n), 32'(1));

    // frame_clr on the same cycle as a pop at col 2 of a later row.
    for (int i = 0; i < 30; i++) push_word();
    clr_on_col2 = 1'b1;
    t6_hit      = 1'b0;
    guard       = 0;
    while (!t6_hit && guard < 60) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    clr_on_col2 = 1'b0;
    check("t6_clr_issued", 32'(t6_hit), 32'(1));
    guard = 0;
    pop_s = 1'b0;
    while (!pop_s && guard < 20) begin
      cycle(1'b1, 1'b0);
      guard++;
    end
    check("t6_beat_after_clr", 32'(pop_s), 32'(1));
    check("t6_sof_after_clr", 32'(sof_s), 32'(1));
    drain("t6", 200);

    repeat (4) cycle(1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
